// File: rtl/dmem_arb_pkg.sv
// Shared types and address helpers for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE1 = 1'b1
    } arb_state_t;

    localparam int WORD_SHIFT = 3;
    localparam int FN_W       = 64;

    // Misaligned, or beyond the last byte of a DEPTH-word memory.
    function automatic logic addr_err(input logic [FN_W-1:0] addr, input int unsigned depth);
        logic [FN_W-1:0] limit;
        limit = FN_W'(depth) << WORD_SHIFT;
        return (addr[WORD_SHIFT-1:0] != '0) || (addr >= limit);
    endfunction

    function automatic logic [FN_W-1:0] word_idx(input logic [FN_W-1:0] addr);
        return addr >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/dmem_addr_decode.sv
// Byte address to word index plus range/alignment error, purely combinational.
module dmem_addr_decode
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32
) (
    input  logic [DATA_W-1:0] addr_i,
    output logic [DATA_W-1:0] idx_o,
    output logic              err_o
);

    logic [FN_W-1:0] addr_ext;

    assign addr_ext = FN_W'(addr_i);
    assign idx_o    = DATA_W'(word_idx(addr_ext));
    assign err_o    = addr_err(addr_ext, DEPTH);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 has priority,
// port 1 gets a forced grant after STARVE_MAX consecutive losses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [DATA_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [DATA_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic              any_gnt;
    logic              win_we;
    logic [DATA_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [DATA_W-1:0] dec_idx;
    logic              dec_err;
    logic              rd_ok;

    logic              p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
    logic              p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!reset) begin
            if (state_q == FORCE1) begin
                if (p1_req)      p1_gnt = 1'b1;
                else if (p0_req) p0_gnt = 1'b1;
            end else begin
                if (p0_req)      p0_gnt = 1'b1;
                else if (p1_req) p1_gnt = 1'b1;
            end
        end
    end

    assign any_gnt   = p0_gnt | p1_gnt;
    assign win_we    = p1_gnt ? p1_we    : p0_we;
    assign win_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign win_wdata = p1_gnt ? p1_wdata : p0_wdata;

    dmem_addr_decode #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_decode (
        .addr_i (win_addr),
        .idx_o  (dec_idx),
        .err_o  (dec_err)
    );

    // An erroring access must not touch memory, so its address is parked at 0.
    assign mem_we    = any_gnt & win_we & ~dec_err;
    assign mem_addr  = (any_gnt && !dec_err) ? dec_idx : '0;
    assign mem_wdata = any_gnt ? win_wdata : '0;

    always_comb begin
        state_d      = NORMAL;
        starve_cnt_d = '0;
        if (state_q == NORMAL && p1_req && !p1_gnt) begin
            if (starve_cnt_q == CNT_W'(STARVE_MAX - 1)) state_d = FORCE1;
            else starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= NORMAL;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign rd_ok = any_gnt & ~win_we & ~dec_err;

    always_comb begin
        p0_rvalid_d = p0_gnt;
        p1_rvalid_d = p1_gnt;
        p0_err_d    = p0_gnt & dec_err;
        p1_err_d    = p1_gnt & dec_err;
        p0_rdata_d  = (p0_gnt && rd_ok) ? mem_rdata : '0;
        p1_rdata_d  = (p1_gnt && rd_ok) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is the loader/debug port used for memory preload and inspection.
- Port 0 has fixed priority. A starvation counter forces periodic grants to port 1.
- Converts byte addresses to word indices and rejects out-of-range accesses.
- Returns read data and error status as a registered response one cycle after each grant.

Parameters:
- DATA_W, 64, data and address width.
- DEPTH, 32, number of memory words; must be a power of two.
- STARVE_MAX, 4, consecutive port-1 losses before port 1 gets a forced grant.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- p0_req  in  1  pipeline access request
- p0_we  in  1  1 = store, 0 = load
- p0_addr  in  DATA_W  byte address
- p0_wdata  in  DATA_W  store data
- p0_gnt  out  1  request accepted this cycle (combinational)
- p0_rvalid  out  1  response valid, registered
- p0_rdata  out  DATA_W  load data, registered
- p0_err  out  1  out-of-range or misaligned, valid with p0_rvalid
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as the p0 ports, for the loader/debug port
- mem_we  out  1  to memory MemWrite
- mem_addr  out  DATA_W  word index to memory Address, zero-extended
- mem_wdata  out  DATA_W  to memory Writedata
- mem_rdata  in  DATA_W  from memory Readdata (combinational read)

Behaviour:
- Reset (sync, active-high): clears state to NORMAL and starve_cnt to 0. Every registered output resets to 0: p*_rvalid, p*_rdata, p*_err. While reset is high, all gnt outputs and mem_we are 0.
- FSM states:
  - NORMAL: winner = port 0 if p0_req, else port 1 if p1_req.
  - FORCE1: winner = port 1 if p1_req, else port 0 if p0_req.
- Starve counter:
  - In NORMAL, increments when p1_req is 1 and p1_gnt is 0; otherwise clears to 0.
  - When the increment would reach STARVE_MAX, the next state is FORCE1 and starve_cnt clears.
- FORCE1 lasts exactly one cycle, then returns to NORMAL, whether or not port 1 was granted.
- Exactly one gnt is high per cycle, at most. gnt is high only for a requesting winner and depends combinationally on req and state. A requester must hold req and all payload until it sees gnt.
- Address decode:
  - word index = addr >> 3.
  - Error if addr[2:0] != 0, or if addr >= DEPTH*8.
- Memory access on a grant:
  - mem_addr = word index; mem_wdata = wdata.
  - mem_we = we AND NOT error. An erroring store never reaches memory.
  - On error, mem_addr is driven to 0.
- Response: the clock edge after a grant sets the winner's rvalid=1 for exactly one cycle.
  - rdata = mem_rdata sampled at that edge for a valid load; 0 for stores and errors.
  - err = decode error.
  - The loser's rvalid is 0.
- Ordering constraint: memory writes on the falling edge. A load granted in the cycle after a store to the same word returns the new data. Within a single cycle only one access exists, so no same-cycle hazard.
- When no port is granted: mem_we=0, mem_addr=0, mem_wdata=0. The mem_* outputs are driven to 0 whenever no grant.
- Back-to-back grants to the same port are allowed every cycle; throughput is 1 access per cycle.
- Reset mid-operation: any pending response is dropped (rvalid=0 the following cycle), and the starvation count is lost.

Decomposition:
- Package dmem_arb_pkg:
  - typedef arb_state_t {NORMAL, FORCE1}
  - localparam WORD_SHIFT = 3
  - function addr_err(addr, depth)
  - function word_idx(addr)
- One sub-module, dmem_addr_decode: combinational, byte address -> word index + error. It is instantiated once on the winner's muxed address.
- The FSM, counter and response registers stay in the top level.

Test Plan:
- Single store then load: p0 store addr 0x10 data 0xDEADBEEF_CAFEF00D, then p0 load 0x10 the next cycle -> p0_gnt each cycle; p0_rvalid on the two following edges; the second rdata is 0xDEADBEEF_CAFEF00D; err=0.
- Contention, no starvation: p0_req and p1_req held high for 10 cycles (STARVE_MAX=4) -> p1_gnt only in cycles 5 and 10; p0_gnt in all other cycles; p1_rvalid exactly in cycles 6 and 11.
- Out of range: p1 store addr 0x100 (DEPTH=32) -> p1_gnt=1, mem_we=0, next cycle p1_rvalid=1, p1_err=1; a subsequent load of word 0 shows unchanged contents.
- Misaligned: p0 load addr 0x0C -> p0_err=1, p0_rdata=0, no memory write.
- Loader preload: p1 writes words 0..31 with value = index*3 while p0 is idle -> 32 consecutive grants; a readback from p0 returns index*3 for every word.
- Reset mid-burst: assert reset during the cycle after a p0 load grant -> p0_rvalid=0 the next cycle, state NORMAL, starve_cnt 0; contention after release gives the first p1 grant at cycle 5 again.
